// File: rtl/demux_stream.sv
// demux_stream: 1:N stream demultiplexer with one registered beat per output channel.
//   Each accepted input beat is steered to a single channel. The channel comes either from
//   `sel` (mode=0) or from an internal round-robin pointer (mode=1). A stalled consumer only
//   blocks beats aimed at its own channel. A beat whose select is out of range is accepted,
//   dropped, and reported one cycle later on sel_err.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode                  0 = select-driven, 1 = round-robin
//   sel                   target channel when mode=0
//   din/din_valid/din_ready   input stream
//   dout/dout_valid/dout_ready  N output channels, channel k at dout[k*W +: W]
//   rr_ptr                current round-robin target
//   sel_err               one-cycle pulse after a beat dropped for an out-of-range select
module demux_stream #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned SW = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    input  logic [W-1:0]  din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [N*W-1:0] dout,
    output logic [N-1:0]  dout_valid,
    input  logic [N-1:0]  dout_ready,
    output logic [SW-1:0] rr_ptr,
    output logic          sel_err
);

    // Padded to the full select range so any select value indexes safely.
    localparam int unsigned NP = 1 << SW;

    logic [SW-1:0]  target;
    logic           in_range;
    logic [NP-1:0]  free_pad;
    logic           accept;
    logic [N-1:0]   load;
    logic [N-1:0]   valid_d;
    logic [N*W-1:0] dout_d;
    logic [SW-1:0]  rr_d;
    logic           err_d;

    assign target   = mode ? rr_ptr : sel;
    assign in_range = (32'(target) < N);

    // A channel is free when empty or being drained this cycle (pass-through, no bubble).
    always_comb begin
        free_pad        = '0;
        free_pad[N-1:0] = ~dout_valid | dout_ready;
    end

    // Out-of-range beats are always taken so they cannot wedge the producer.
    assign din_ready = in_range ? free_pad[target] : 1'b1;
    assign accept    = din_valid & din_ready & in_range;

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            load[k]           = accept && (32'(target) == k);
            valid_d[k]        = load[k] | (dout_valid[k] & ~dout_ready[k]);
            dout_d[k*W +: W]  = load[k] ? din : dout[k*W +: W];
        end
    end

    always_comb begin
        rr_d = rr_ptr;
        if (mode && accept) begin
            rr_d = (32'(rr_ptr) == N - 1) ? '0 : rr_ptr + 1'b1;
        end
    end

    assign err_d = din_valid & ~in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= '0;
            rr_ptr     <= '0;
            sel_err    <= 1'b0;
        end else begin
            dout       <= dout_d;
            dout_valid <= valid_d;
            rr_ptr     <= rr_d;
            sel_err    <= err_d;
        end
    end

endmodule
